// File: rtl/vae_pkg.sv
// Shared types for the result output path: lane geometry, the packed DMA word
// and the {last, word} entry stored in the result FIFO.
package vae_pkg;

  localparam int RESULT_W = 16;
  localparam int DMA_W    = 64;
  localparam int LANES    = DMA_W / RESULT_W;
  localparam int LANE_W   = $clog2(LANES);

  typedef logic [LANES-1:0][RESULT_W-1:0] word_t;

  typedef struct packed {
    logic  last;
    word_t word;
  } fifo_entry_t;

endpackage

// File: rtl/result_fifo.sv
// First-word fall-through FIFO of packed result words. The head is read straight
// from registered storage, so there is no combinational path from push to head.
module result_fifo
  import vae_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  fifo_entry_t            push_entry,
  input  logic                   pop,
  output fifo_entry_t            head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_LVL);
  assign level = count;

  // A full FIFO still takes a word when the head leaves on the same edge.
  assign do_pop  = !clr && pop && !empty;
  assign do_push = !clr && push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Empty presents zeros so the reset state of the head is all-zero.
  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/result_packer.sv
// Packs 16-bit accelerator results four per 64-bit DMA word, closing words early
// at end of frame, and buffers them for the DMA write channel. Optional build
// macro RESULT_RELU_EN clamps negative results to zero before packing.
module result_packer
  import vae_pkg::*;
#(
  parameter int FRAME_LEN = 64,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       res_valid,
  input  logic signed [RESULT_W-1:0] res_data,
  output logic [DMA_W-1:0]           out_data,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

`ifdef RESULT_RELU_EN
  function automatic logic signed [RESULT_W-1:0] relu(input logic signed [RESULT_W-1:0] v);
    return (v < 0) ? '0 : v;
  endfunction
`endif

  logic signed [RESULT_W-1:0] res_val;
  logic [LANE_W-1:0]          lane_cnt;
  logic [FW-1:0]              frame_cnt;
  word_t                      pack_p0;
  word_t                      merged;
  logic                       last_res;
  logic                       push;
  logic                       pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  fifo_entry_t                push_entry;
  fifo_entry_t                head;

`ifdef RESULT_RELU_EN
  assign res_val = relu(res_data);
`else
  assign res_val = res_data;
`endif

  assign last_res = (frame_cnt == FW'(FRAME_LEN - 1));

  // Lanes above lane_cnt are still zero in pack_p0, which gives the end-of-frame padding.
  always_comb begin
    merged           = pack_p0;
    merged[lane_cnt] = res_val;
  end

  assign push       = !clr && res_valid && ((lane_cnt == LANE_W'(LANES - 1)) || last_res);
  assign pop        = out_valid && out_ready;
  assign push_entry = '{last: last_res, word: merged};

  // Stage p0: pack register and framing counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt  <= '0;
      frame_cnt <= '0;
      pack_p0   <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      lane_cnt  <= '0;
      frame_cnt <= '0;
      pack_p0   <= '0;
      overflow  <= 1'b0;
    end else if (res_valid) begin
      if (push) begin
        pack_p0  <= '0;
        lane_cnt <= '0;
      end else begin
        pack_p0  <= merged;
        lane_cnt <= lane_cnt + 1'b1;
      end
      frame_cnt <= last_res ? '0 : frame_cnt + 1'b1;
      // Counters keep advancing on a drop so framing stays aligned.
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (level)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head.word;
  assign out_last  = head.last;

endmodule
